// File: rtl/accum_share_ctrl.sv
// Round-robin share of one add-accumulator among NUM_REQ requesters; grant -> clear -> BURST_LEN beats -> result.
// Latency: grant 1 cycle after req in IDLE, result_valid BURST_LEN+2 cycles after; result held until result_ready.
// Optional ACCUM_SATURATE_EN: accumulator clamps to all-ones on carry instead of wrapping.
module accum_share_ctrl #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          data_ack,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DATA_W-1:0]           result,
  output logic                        overflow,
  output logic [2:0]                  result_id,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        abort
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_ID   = 3'(NUM_REQ - 1);
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [2:0]          rr_q, rr_d;
  logic [2:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [3:0]          cnt_q, cnt_d;

  // Arbitration: rotate requests so the rr pointer sits at bit 0, take the lowest set bit.
  logic [NUM_REQ-1:0]  req_rot;
  logic [2:0]          pick_off;
  logic [2:0]          pick_rem;
  logic [2:0]          pick_idx;
  logic                pick_vld;

  always_comb begin
    req_rot  = NUM_REQ'({req, req} >> rr_q);
    pick_vld = |req;
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = 3'(k);
    end
    pick_rem = LAST_ID - rr_q;
    if (pick_off > pick_rem) pick_idx = pick_off - pick_rem - 3'd1;
    else                     pick_idx = rr_q + pick_off;
  end

  logic [DATA_W-1:0]   own_word;
  logic                own_req;
  logic [DATA_W:0]     acc_sum;
  logic [2:0]          next_rr;

  always_comb begin
    own_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) own_word = own_word | req_data[i*DATA_W +: DATA_W];
    end
  end

  assign own_req = |(req & grant_q);
  assign acc_sum = {1'b0, acc_q} + {1'b0, own_word};
  assign next_rr = (owner_q == LAST_ID) ? 3'd0 : owner_q + 3'd1;

  logic [NUM_REQ-1:0]  ack_c;
  logic                abort_c;
  logic                valid_c;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    ack_c   = '0;
    abort_c = 1'b0;
    valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          grant_d = ONE_HOT0 << pick_idx;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        acc_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
        if (!own_req) begin
          abort_c = 1'b1;
          grant_d = '0;
          rr_d    = next_rr;
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (!own_req) begin
          abort_c = 1'b1;
          grant_d = '0;
          rr_d    = next_rr;
          state_d = S_IDLE;
        end else begin
          ack_c = grant_q;
`ifdef ACCUM_SATURATE_EN
          // Once any carry has happened the sum is pinned at full scale for the rest of the burst.
          acc_d = (ovf_q || acc_sum[DATA_W]) ? '1 : acc_sum[DATA_W-1:0];
`else
          acc_d = acc_sum[DATA_W-1:0];
`endif
          ovf_d = ovf_q | acc_sum[DATA_W];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end

      S_DONE: begin
        valid_c = 1'b1;
        if (result_ready) begin
          grant_d = '0;
          rr_d    = next_rr;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // Reset takes effect on the pulse outputs in the same cycle it is asserted.
    if (reset) begin
      ack_c   = '0;
      abort_c = 1'b0;
      valid_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_ack     = ack_c;
  assign abort        = abort_c;
  assign result_valid = valid_c;
  assign grant        = grant_q;
  assign result       = acc_q;
  assign overflow     = ovf_q;
  assign result_id    = owner_q;

endmodule

// File: tb/tb_accum_share_ctrl.sv
// Bench for accum_share_ctrl: directed scenarios plus random bursts against a transaction-level model.
module tb_accum_share_ctrl;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 4;
  localparam int BURST_LEN = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      result_ready = 1'b0;
  logic [NUM_REQ-1:0]        data_ack;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         result;
  logic                      overflow;
  logic [2:0]                result_id;
  logic                      result_valid;
  logic                      abort;

  int n_cmp = 0;
  int n_err = 0;
  int rr_m  = 0;

  accum_share_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .data_ack(data_ack), .grant(grant), .result(result), .overflow(overflow),
    .result_id(result_id), .result_valid(result_valid), .result_ready(result_ready),
    .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] m);
    for (int i = 0; i < NUM_REQ; i++)
      if (m[(rr_m + i) % NUM_REQ]) return (rr_m + i) % NUM_REQ;
    return 0;
  endfunction

  function automatic int exp_result(input int total);
`ifdef ACCUM_SATURATE_EN
    return (total > 15) ? 15 : total;
`else
    return total % 16;
`endif
  endfunction

  task automatic finish_abort(input int w);
    tick;
    req = '0; result_ready = 1'b0;
    settle;
    chk("post_abort_pulse", abort, 0);
    chk("post_abort_grant", grant, 0);
    chk("post_abort_valid", result_valid, 0);
    rr_m = (w + 1) % NUM_REQ;
  endtask

  // fixed_word < 0: random owner data; abort_at: -1 none, 0 in CLEAR, b = beat b.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int fixed_word,
                         input int abort_at, input int hold);
    int w, total, word;
    logic [NUM_REQ-1:0] oh, r;
    tick;
    req = mask; req_data = $urandom; result_ready = 1'($urandom);
    settle;
    w  = pick(mask);
    oh = NUM_REQ'(1 << w);
    chk("idle_grant", grant, 0);

    tick;
    r = NUM_REQ'($urandom) & ~oh;
    if (abort_at != 0) r = r | oh;
    req = r; req_data = $urandom; result_ready = 1'($urandom);
    settle;
    chk("clear_grant", grant, oh);
    chk("clear_ack", data_ack, 0);
    chk("clear_abort", abort, (abort_at == 0));
    if (abort_at == 0) begin
      finish_abort(w);
      return;
    end

    total = 0;
    for (int b = 1; b <= BURST_LEN; b++) begin
      tick;
      r = NUM_REQ'($urandom) & ~oh;
      if (abort_at != b) r = r | oh;
      word = (fixed_word >= 0) ? fixed_word : int'($urandom_range(0, 15));
      req = r; req_data = $urandom; result_ready = 1'($urandom);
      req_data[w*DATA_W +: DATA_W] = DATA_W'(word);
      settle;
      if (abort_at == b) begin
        chk("abort_pulse", abort, 1);
        chk("abort_no_ack", data_ack, 0);
        chk("abort_no_valid", result_valid, 0);
        finish_abort(w);
        return;
      end
      chk("beat_ack", data_ack, oh);
      chk("beat_valid", result_valid, 0);
      total += word;
    end

    for (int h = 0; h <= hold; h++) begin
      tick;
      req = NUM_REQ'($urandom); req_data = $urandom; result_ready = (h == hold);
      settle;
      chk("done_valid", result_valid, 1);
      chk("done_result", result, exp_result(total));
      chk("done_overflow", overflow, (total > 15));
      chk("done_id", result_id, w);
      chk("done_grant", grant, oh);
    end

    tick;
    req = '0; result_ready = 1'b0;
    settle;
    chk("accept_valid", result_valid, 0);
    chk("accept_grant", grant, 0);
    rr_m = (w + 1) % NUM_REQ;
  endtask

  initial begin
    reset = 1'b1;
    tick; tick;
    settle;
    chk("rst_grant", grant, 0);
    chk("rst_ack", data_ack, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_id", result_id, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_abort", abort, 0);
    reset = 1'b0;
    rr_m = 0;

    // All requesting: owners rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_txn(4'b1111, -1, -1, 0);
    run_txn(4'b0001, 3, -1, 0);
    run_txn(4'b0001, 5, -1, 0);
    // Owner 2 drops after its second beat; next grant goes to 3.
    run_txn(4'b0100, -1, 3, 0);
    run_txn(4'b1001, -1, -1, 0);
    run_txn(4'b0010, 7, -1, 5);
    run_txn(4'b0001, 0, -1, 0);
    run_txn(4'b1000, 15, -1, 1);

    for (int n = 0; n < 40; n++) begin
      logic [NUM_REQ-1:0] m;
      int ab;
      m  = NUM_REQ'($urandom_range(1, 15));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BURST_LEN)) : -1;
      run_txn(m, -1, ab, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a burst.
    tick; req = 4'b0001; req_data = 16'h000F; settle;
    tick; settle;
    tick; settle;
    tick; settle;
    tick; reset = 1'b1; settle;
    chk("midrst_ack", data_ack, 0);
    tick; reset = 1'b0; req = 4'b0001; settle;
    chk("midrst_grant", grant, 0);
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_id", result_id, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_ack_idle", data_ack, 0);
    chk("midrst_abort", abort, 0);
    tick; settle;
    chk("restart_grant", grant, 4'b0001);
    chk("restart_clear_ack", data_ack, 0);
    tick; settle;
    chk("restart_beat_ack", data_ack, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
